pio_exec_ctrl: RTL and testbench

- Per-state-machine execution controller that sits directly upstream of the PIO program counter.
- Takes the fetched 16-bit instruction and produces the counter's `jmp`, `din` (jump target) and `stalled` inputs.
- Evaluates the eight JMP conditions, holds WAIT instructions until their condition is met, and sequences the instruction delay field.
- Emits X/Y decrement strobes to the scratch-register block.

---
 rtl/pio_exec_ctrl.sv | 68 ++++++
 tb/tb_pio_exec_ctrl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/pio_exec_ctrl.sv
// pio_exec_ctrl: PIO execution controller evaluating JMP/WAIT and sequencing instruction delays
module pio_exec_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              penable,
  input  logic              imm,
  input  logic [15:0]       instr,
  input  logic [2:0]        sideset_bits,
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] y,
  input  logic              jmp_pin,
  input  logic              osre,
  input  logic              wait_ok,
  output logic              jmp,
  output logic [ADDR_W-1:0] jmp_target,
  output logic              stalled,
  output logic              dec_x,
  output logic              dec_y,
  output logic              delaying,
  output logic [4:0]        delay_cnt
);
  typedef enum logic {EXEC, DELAY} state_t;
  state_t state, state_n;
  logic [4:0] cnt, cnt_n, d;
  logic [2:0] op, cond, ss;
  logic adv, ex, hold, cond_true, jmp_go;
  assign op = instr[15:13];
  assign cond = instr[7:5];
  assign ss = sideset_bits > 3'd5 ? 3'd5 : sideset_bits;
  assign d = instr[12:8] & (5'h1F >> ss);
  assign adv = penable | imm;
  // a forced instruction pre-empts any pending delay and is evaluated as if in EXEC
  assign ex = state == EXEC || imm;
  assign hold = ex && op == 3'b001 && !wait_ok;
  assign cond_true = cond == 3'd0 ? 1'b1 :
                     cond == 3'd1 ? x == '0 :
                     cond == 3'd2 ? x != '0 :
                     cond == 3'd3 ? y == '0 :
                     cond == 3'd4 ? y != '0 :
                     cond == 3'd5 ? x != y :
                     cond == 3'd6 ? jmp_pin : !osre;
  assign jmp_go = !reset && adv && ex && op == 3'b000;
  assign jmp = jmp_go && cond_true;
  assign dec_x = jmp_go && cond == 3'd2;
  assign dec_y = jmp_go && cond == 3'd4;
  assign jmp_target = instr[ADDR_W-1:0];
  assign stalled = !reset && (ex ? hold : 1'b1);
  assign delaying = !reset && state == DELAY;
  assign delay_cnt = reset ? 5'd0 : cnt;
  // next state: load delay on completion, count down in DELAY, freeze when not advancing
  always_comb begin
    state_n = !adv ? state : ex ? (hold || d == '0 ? EXEC : DELAY) : (cnt == 5'd1 ? EXEC : DELAY);
    cnt_n = !adv ? cnt : ex ? (hold ? 5'd0 : d) : cnt - 5'd1;
  end
  // state and delay counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EXEC;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  end
endmodule

// File: tb/tb_pio_exec_ctrl.sv
// tb_pio_exec_ctrl: randomized and directed checks against a cycle-level behavioural model
module tb_pio_exec_ctrl;
  logic clk = 0;
  logic reset, penable, imm, jmp_pin, osre, wait_ok;
  logic [15:0] instr;
  logic [2:0] sideset_bits;
  logic [31:0] x, y;
  logic jmp, stalled, dec_x, dec_y, delaying;
  logic [4:0] jmp_target, delay_cnt;
  int rem, rem_next, n_chk, n_err;

  pio_exec_ctrl dut (
    .clk(clk), .reset(reset), .penable(penable), .imm(imm), .instr(instr),
    .sideset_bits(sideset_bits), .x(x), .y(y), .jmp_pin(jmp_pin), .osre(osre),
    .wait_ok(wait_ok), .jmp(jmp), .jmp_target(jmp_target), .stalled(stalled),
    .dec_x(dec_x), .dec_y(dec_y), .delaying(delaying), .delay_cnt(delay_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // rem = number of delay cycles still owed by the current instruction
  task automatic sample();
    int ss, dm, op, cnd;
    bit a, ex, hold, ct;
    @(negedge clk);
    ss = sideset_bits > 5 ? 5 : int'(sideset_bits);
    dm = int'(instr[12:8]) % (32 >> ss);
    op = int'(instr[15:13]);
    cnd = int'(instr[7:5]);
    a = penable || imm;
    ex = rem == 0 || imm;
    hold = ex && op == 1 && !wait_ok;
    case (cnd)
      0: ct = 1;
      1: ct = x == 0;
      2: ct = x != 0;
      3: ct = y == 0;
      4: ct = y != 0;
      5: ct = x != y;
      6: ct = jmp_pin;
      default: ct = !osre;
    endcase
    check("jmp_target", jmp_target, instr[4:0]);
    check("jmp", jmp, !reset && a && ex && op == 0 && ct);
    check("dec_x", dec_x, !reset && a && ex && op == 0 && cnd == 2);
    check("dec_y", dec_y, !reset && a && ex && op == 0 && cnd == 4);
    check("stalled", stalled, reset ? 0 : (ex ? hold : 1));
    check("delaying", delaying, !reset && rem > 0);
    check("delay_cnt", delay_cnt, reset ? 0 : rem);
    rem_next = reset ? 0 : !a ? rem : ex ? (hold ? 0 : dm) : rem - 1;
  endtask

  task automatic tick();
    @(posedge clk);
    rem = rem_next;
    #1;
  endtask

  task automatic step();
    sample();
    tick();
  endtask

  initial begin
    reset = 1; penable = 1; imm = 0; instr = 16'h000C; sideset_bits = 0;
    x = 0; y = 0; jmp_pin = 0; osre = 0; wait_ok = 1; rem = 0;
    sample();
    check("reset_jmp", jmp, 0);
    check("reset_stalled", stalled, 0);
    tick();
    reset = 0;
    step();
    sample();
    check("jmp_always", jmp, 1);
    check("jmp_addr", jmp_target, 5'h0C);
    check("jmp_nostall", stalled, 0);
    tick();
    instr = {3'b000, 5'd0, 3'd2, 5'd1}; x = 3;
    sample(); check("jxdec_jmp", jmp, 1); check("jxdec_dec", dec_x, 1); tick();
    x = 0;
    sample(); check("jxdec0_jmp", jmp, 0); check("jxdec0_dec", dec_x, 1); tick();
    instr = {3'b000, 5'd0, 3'd5, 5'd1}; x = 7; y = 7;
    sample(); check("jxney_eq", jmp, 0); tick();
    instr = {3'b010, 5'd3, 3'd0, 5'd0};
    sample(); check("dly_issue", stalled, 0); tick();
    instr = 16'h4000;
    for (int i = 3; i >= 1; i--) begin
      sample(); check("dly_stall", stalled, 1); check("dly_cnt", delay_cnt, i); tick();
    end
    sample(); check("dly_done", stalled, 0); tick();
    instr = {3'b010, 5'b11011, 3'd0, 5'd0}; sideset_bits = 2;
    step(); instr = 16'h4000;
    sample(); check("ss2_cnt", delay_cnt, 3); tick();
    repeat (3) step();
    instr = {3'b010, 5'b11011, 3'd0, 5'd0}; sideset_bits = 5;
    step();
    sample(); check("ss5_nodelay", delaying, 0); tick();
    sideset_bits = 0; instr = {3'b001, 5'd2, 3'd0, 5'd0}; wait_ok = 0;
    repeat (4) begin sample(); check("wait_stall", stalled, 1); tick(); end
    wait_ok = 1;
    sample(); check("wait_issue", stalled, 0); tick();
    sample(); check("wait_dly", delay_cnt, 2); tick();
    penable = 0;
    sample(); check("freeze", delay_cnt, 1); tick();
    sample(); check("freeze2", delay_cnt, 1); tick();
    penable = 1;
    step();
    instr = {3'b010, 5'd4, 3'd0, 5'd0};
    step();
    instr = 16'h4000;
    sample(); check("pre_rst_cnt", delay_cnt, 4); tick();
    reset = 1; step(); reset = 0;
    sample(); check("rst_stalled", stalled, 0); check("rst_dly", delaying, 0); check("rst_cnt", delay_cnt, 0); tick();
    instr = {3'b010, 5'd4, 3'd0, 5'd0};
    step();
    instr = 16'h4000; imm = 1;
    sample(); check("imm_stall", stalled, 0); tick();
    imm = 0;
    sample(); check("imm_abandon", delaying, 0); tick();
    for (int i = 0; i < 3000; i++) begin
      reset = $urandom_range(0, 99) < 3;
      penable = $urandom_range(0, 3) != 0;
      imm = $urandom_range(0, 9) == 0;
      instr = 16'($urandom);
      instr[15:13] = 3'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) instr[12:8] = 5'($urandom_range(0, 3));
      sideset_bits = 3'($urandom_range(0, 7));
      x = $urandom_range(0, 2);
      y = $urandom_range(0, 2);
      jmp_pin = 1'($urandom);
      osre = 1'($urandom);
      wait_ok = 1'($urandom);
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
